usb_fs_in_pe_pp: RTL
====================

# usb_fs_in_pe_pp

Parametrised, double-buffered USB full-speed IN protocol engine. It sits between the endpoint-side IN data producers and the USB transmit/receive packet layer. Each endpoint owns two packet banks (ping-pong), so firmware or gateware can fill one bank while the other is transmitted or retried. Adds per-endpoint isochronous mode, zero-length packets, explicit packet length and an ACK timeout.

## Interface
- NUM_IN_EPS, 4, number of IN endpoints (1..16); endpoint n uses bit n of every per-endpoint vector
- MAX_IN_PACKET_SIZE, 64, bytes per bank; power of two, 8..64
- ISO_EPS, 0, NUM_IN_EPS-bit mask; bit set = isochronous endpoint
- ACK_TIMEOUT, 255, clocks to wait for a handshake after the last data byte (1..1023)
- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- reset_ep  in  NUM_IN_EPS  sync per-endpoint flush
- dev_addr  in  7  device address
- in_ep_data_free  out  NUM_IN_EPS  fill bank can accept a byte
- in_ep_data_put  in  NUM_IN_EPS  write in_ep_data to fill bank; one-hot
- in_ep_data  in  8  byte to write
- in_ep_data_done  in  NUM_IN_EPS  commit fill bank, possibly 0 bytes
- in_ep_stall  in  NUM_IN_EPS  level; force endpoint to STALL
- in_ep_acked  out  NUM_IN_EPS  one-clock pulse when a bank is released
- rx_pkt_start, rx_pkt_end, rx_pkt_valid  in  1 each  receive strobes
- rx_pid  in  4; rx_addr  in  7; rx_endp  in  4; rx_frame_num  in  11  last received token fields
- tx_pkt_start  out  1  one-clock strobe to start a packet
- tx_pid  out  4  PID for tx_pkt_start
- tx_data_avail  out  1  payload byte pending
- tx_data_get  in  1  transmitter consumed tx_data
- tx_data  out  8  current payload byte
- tx_pkt_end  in  1  transmitter finished packet

## Operation
- Buffer: inferred RAM, NUM_IN_EPS × 2 × MAX_IN_PACKET_SIZE bytes, address {ep, bank, offset}, one write port, one registered read port.
- Per-endpoint state: fill_bank, send_bank (1 bit each), bank_full[1:0], bank_len[1:0] (clog2(MAX)+1 bits), put_ptr, data_toggle, stalled.
- Fill: in_ep_data_free[n] = !stalled && !bank_full[fill_bank]. A put writes the byte at put_ptr and increments it. The bank commits (bank_full set, bank_len = put_ptr, fill_bank flips, put_ptr cleared) on done, or when put_ptr reaches MAX. Put and done in the same cycle: the byte counts, then the bank commits. A put while not free is ignored. Done with put_ptr 0 commits a zero-length packet.
- Token decode: valid = rx_pkt_end && rx_pkt_valid && rx_pid[1:0]==01 && rx_addr==dev_addr && rx_endp<NUM_IN_EPS. IN = rx_pid[3:2]==10; SETUP = 11. ACK = rx_pkt_end && rx_pkt_valid && rx_pid==0010.
- Transfer FSM (IDLE, RCVD_IN, SEND_DATA, WAIT_ACK):
  - IDLE: an IN token latches current_endp and moves to RCVD_IN.
  - RCVD_IN: asserts tx_pkt_start with one of the following, in priority order:
    - stalled: STALL (1110), then IDLE.
    - bank_full[send_bank]: DATAx, then SEND_DATA. x = data_toggle, or 0 for ISO endpoints.
    - ISO endpoint, no bank: zero-length DATA0 (0011), then IDLE.
    - otherwise: NAK (1010), then IDLE.
  - SEND_DATA: tx_data_avail = get_ptr < bank_len; tx_data_get && avail increments get_ptr. When not avail: ISO endpoints release the bank and go to IDLE; others go to WAIT_ACK with the timer cleared.
  - WAIT_ACK, checked in order:
    - ACK: release bank, flip data_toggle, go to IDLE.
    - IN token: rollback, go to RCVD_IN (retransmit the same bank, same PID).
    - other rx_pkt_end, or timer == ACK_TIMEOUT: rollback, go to IDLE.
- Release: clear bank_full[send_bank], flip send_bank, pulse in_ep_acked[n]. Rollback: get_ptr = 0; the bank stays full.
- stalled is set while in_ep_stall is high. Once set, it clears only on a SETUP to that endpoint with in_ep_stall low. A SETUP always sets data_toggle to 1.
- reset_ep[n]: clears both banks, put_ptr, the pointers, data_toggle and stalled. If n == current_endp and the FSM is not IDLE, the FSM goes to IDLE with no release pulse.

## Timing
- Reset values: in_ep_data_free 0, in_ep_acked 0, tx_pkt_start 0, tx_pid 0000, tx_data_avail 0, tx_data 0; FSM IDLE; all banks empty; toggles 0.
- in_ep_data_free rises one clock after reset_n deasserts.
- tx_pkt_start is asserted exactly one clock after the token's rx_pkt_end.
- tx_data is valid from one clock after entering SEND_DATA. After each get it updates one clock later; the transmitter does not get on consecutive clocks.
- in_ep_acked pulses in the clock after the ACK's rx_pkt_end. The released bank's free flag is visible on the same clock.
- A committed bank is sendable from the clock after commit.

## Test plan
- Put 10 bytes plus done on EP1; IN EP1 -> DATA0, 10 bytes in order, tx_data_avail drops; ACK -> in_ep_acked[1] pulse; next IN -> NAK.
- Fill both EP2 banks (64 bytes auto-commit, then 3 bytes + done); free drops; IN/ACK twice -> DATA0 64 bytes, then DATA1 3 bytes; free returns after the first ACK.
- IN EP1, data sent, no handshake for ACK_TIMEOUT clocks -> IDLE; IN again -> same DATA0 and same bytes; ACK -> toggle 1.
- ISO EP3, bank holding 5 bytes: IN -> DATA0, 5 bytes, bank released without ACK; IN on empty -> zero-length DATA0.
- in_ep_stall[0] pulse; IN EP0 -> STALL; SETUP EP0 -> next IN with data gives DATA1.
- Assert reset_ep[1] mid SEND_DATA -> FSM IDLE, no acked pulse, EP1 empty; reset_n low mid-transfer -> all outputs at reset values immediately.

Source files
------------

// File: rtl/usb_fs_in_pe_pp.sv
// rtl/usb_fs_in_pe_pp.sv - double-buffered USB full-speed IN protocol engine
module usb_fs_in_pe_pp #(
    parameter int                    NUM_IN_EPS         = 4,
    parameter int                    MAX_IN_PACKET_SIZE = 64,
    parameter logic [NUM_IN_EPS-1:0] ISO_EPS            = '0,
    parameter int                    ACK_TIMEOUT        = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_IN_EPS-1:0] reset_ep,
    input  logic [6:0]            dev_addr,
    output logic [NUM_IN_EPS-1:0] in_ep_data_free,
    input  logic [NUM_IN_EPS-1:0] in_ep_data_put,
    input  logic [7:0]            in_ep_data,
    input  logic [NUM_IN_EPS-1:0] in_ep_data_done,
    input  logic [NUM_IN_EPS-1:0] in_ep_stall,
    output logic [NUM_IN_EPS-1:0] in_ep_acked,
    input  logic                  rx_pkt_start,
    input  logic                  rx_pkt_end,
    input  logic                  rx_pkt_valid,
    input  logic [3:0]            rx_pid,
    input  logic [6:0]            rx_addr,
    input  logic [3:0]            rx_endp,
    input  logic [10:0]           rx_frame_num,
    output logic                  tx_pkt_start,
    output logic [3:0]            tx_pid,
    output logic                  tx_data_avail,
    input  logic                  tx_data_get,
    output logic [7:0]            tx_data,
    input  logic                  tx_pkt_end
);
    localparam int PW    = $clog2(MAX_IN_PACKET_SIZE);
    localparam int LW    = PW + 1;
    localparam int EW    = (NUM_IN_EPS > 1) ? $clog2(NUM_IN_EPS) : 1;
    localparam int AW    = EW + 1 + PW;
    localparam int DEPTH = NUM_IN_EPS * 2 * MAX_IN_PACKET_SIZE;

    typedef enum logic [1:0] {S_IDLE, S_RCVD_IN, S_SEND_DATA, S_WAIT_ACK} state_t;

    state_t                           r_state, w_state_next;
    logic                             r_ready;
    logic [NUM_IN_EPS-1:0]            r_fill_bank, r_send_bank, r_toggle, r_stalled, r_acked;
    logic [NUM_IN_EPS-1:0][1:0]       r_bank_full;
    logic [NUM_IN_EPS-1:0][1:0][LW-1:0] r_bank_len;
    logic [NUM_IN_EPS-1:0][LW-1:0]    r_put_ptr;
    logic [EW-1:0]                    r_cur_ep;
    logic [LW-1:0]                    r_get_ptr;
    logic [9:0]                       r_timer;
    logic [7:0]                       r_mem [DEPTH];
    logic [7:0]                       r_tx_data;

    logic                             w_tok, w_in_tok, w_setup_tok, w_ack;
    logic [EW-1:0]                    w_rx_ep;
    logic [NUM_IN_EPS-1:0]            w_free, w_commit;
    logic [NUM_IN_EPS-1:0][LW-1:0]    w_ptr_next;
    logic                             w_cur_full, w_cur_iso, w_avail, w_abort;
    logic [LW-1:0]                    w_cur_len;
    logic                             w_tx_start, w_release, w_flip;
    logic [3:0]                       w_tx_pid;
    logic                             w_wr_en;
    logic [AW-1:0]                    w_wr_addr;
    logic                             w_unused;

    assign w_unused    = ^{rx_pkt_start, rx_frame_num, tx_pkt_end};
    assign w_tok       = rx_pkt_end && rx_pkt_valid && (rx_pid[1:0] == 2'b01) &&
                         (rx_addr == dev_addr) && ({1'b0, rx_endp} < 5'(NUM_IN_EPS));
    assign w_in_tok    = w_tok && (rx_pid[3:2] == 2'b10);
    assign w_setup_tok = w_tok && (rx_pid[3:2] == 2'b11);
    assign w_ack       = rx_pkt_end && rx_pkt_valid && (rx_pid == 4'b0010);
    assign w_rx_ep     = rx_endp[EW-1:0];

    assign w_cur_full  = r_bank_full[r_cur_ep][r_send_bank[r_cur_ep]];
    assign w_cur_len   = r_bank_len[r_cur_ep][r_send_bank[r_cur_ep]];
    assign w_cur_iso   = ISO_EPS[r_cur_ep];
    assign w_avail     = (r_state == S_SEND_DATA) && (r_get_ptr < w_cur_len);
    assign w_abort     = (r_state != S_IDLE) && reset_ep[r_cur_ep];

    // Fill-side bookkeeping: free flag, next put pointer and commit condition per endpoint
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        for (int n = 0; n < NUM_IN_EPS; n++) begin
            w_free[n]     = r_ready && !r_stalled[n] && !r_bank_full[n][r_fill_bank[n]];
            w_ptr_next[n] = r_put_ptr[n] + LW'(in_ep_data_put[n] && w_free[n]);
            w_commit[n]   = w_free[n] && (in_ep_data_done[n] ||
                            (w_ptr_next[n] == LW'(MAX_IN_PACKET_SIZE)));
            if (in_ep_data_put[n] && w_free[n] && !reset_ep[n]) begin
                w_wr_en   = 1'b1;
                w_wr_addr = {EW'(n), r_fill_bank[n], r_put_ptr[n][PW-1:0]};
            end
        end
    end

    // Packet buffer write port
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[w_wr_addr] <= in_ep_data;
    end

    // Registered read port follows the current get pointer of the bank being sent
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_tx_data <= 8'h00;
        else          r_tx_data <= r_mem[{r_cur_ep, r_send_bank[r_cur_ep], r_get_ptr[PW-1:0]}];
    end

    // Transfer FSM next state, handshake PID selection and bank release decisions
    always_comb begin
        w_state_next = r_state;
        w_tx_start   = 1'b0;
        w_tx_pid     = 4'b0000;
        w_release    = 1'b0;
        w_flip       = 1'b0;
        case (r_state)
            S_IDLE: if (w_in_tok) w_state_next = S_RCVD_IN;
            S_RCVD_IN: begin
                w_tx_start = 1'b1;
                if (r_stalled[r_cur_ep]) begin
                    w_tx_pid     = 4'b1110;
                    w_state_next = S_IDLE;
                end else if (w_cur_full) begin
                    w_tx_pid     = {(w_cur_iso ? 1'b0 : r_toggle[r_cur_ep]), 3'b011};
                    w_state_next = S_SEND_DATA;
                end else if (w_cur_iso) begin
                    w_tx_pid     = 4'b0011;
                    w_state_next = S_IDLE;
                end else begin
                    w_tx_pid     = 4'b1010;
                    w_state_next = S_IDLE;
                end
            end
            S_SEND_DATA: begin
                if (!w_avail) begin
                    if (w_cur_iso) begin
                        w_release    = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_WAIT_ACK;
                    end
                end
            end
            S_WAIT_ACK: begin
                if (w_ack) begin
                    w_release    = 1'b1;
                    w_flip       = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_in_tok) begin
                    w_state_next = S_RCVD_IN;
                end else if (rx_pkt_end || (r_timer == 10'(ACK_TIMEOUT))) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_state_next = S_IDLE;
            w_release    = 1'b0;
            w_flip       = 1'b0;
        end
    end

    // FSM state, latched endpoint, get pointer (cleared whenever a transfer is not live) and ACK timer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b0;
            r_cur_ep  <= '0;
            r_get_ptr <= '0;
            r_timer   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ready <= 1'b1;
            if ((r_state == S_IDLE) && w_in_tok) r_cur_ep <= w_rx_ep;
            r_timer <= (r_state == S_WAIT_ACK) ? r_timer + 10'd1 : 10'd0;
            if ((w_state_next == S_SEND_DATA) || (w_state_next == S_WAIT_ACK)) begin
                if (tx_data_get && w_avail) r_get_ptr <= r_get_ptr + LW'(1);
            end else begin
                r_get_ptr <= '0;
            end
        end
    end

    // Per-endpoint bank state: fill/commit, release, stall, data toggle and flush
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fill_bank <= '0;
            r_send_bank <= '0;
            r_toggle    <= '0;
            r_stalled   <= '0;
            r_acked     <= '0;
            r_bank_full <= '0;
            r_bank_len  <= '0;
            r_put_ptr   <= '0;
        end else begin
            for (int n = 0; n < NUM_IN_EPS; n++) begin
                r_acked[n] <= 1'b0;
                if (reset_ep[n]) begin
                    r_fill_bank[n] <= 1'b0;
                    r_send_bank[n] <= 1'b0;
                    r_toggle[n]    <= 1'b0;
                    r_stalled[n]   <= 1'b0;
                    r_bank_full[n] <= 2'b00;
                    r_bank_len[n]  <= '0;
                    r_put_ptr[n]   <= '0;
                end else begin
                    if (in_ep_stall[n])
                        r_stalled[n] <= 1'b1;
                    else if (w_setup_tok && (w_rx_ep == EW'(n)))
                        r_stalled[n] <= 1'b0;
                    if (w_setup_tok && (w_rx_ep == EW'(n)))
                        r_toggle[n] <= 1'b1;
                    else if (w_flip && (r_cur_ep == EW'(n)))
                        r_toggle[n] <= ~r_toggle[n];
                    if (w_commit[n]) begin
                        r_bank_full[n][r_fill_bank[n]] <= 1'b1;
                        r_bank_len[n][r_fill_bank[n]]  <= w_ptr_next[n];
                        r_fill_bank[n]                 <= ~r_fill_bank[n];
                        r_put_ptr[n]                   <= '0;
                    end else if (w_free[n]) begin
                        r_put_ptr[n] <= w_ptr_next[n];
                    end
                    if (w_release && (r_cur_ep == EW'(n))) begin
                        r_bank_full[n][r_send_bank[n]] <= 1'b0;
                        r_send_bank[n]                 <= ~r_send_bank[n];
                        r_acked[n]                     <= 1'b1;
                    end
                end
            end
        end
    end

    assign in_ep_data_free = w_free;
    assign in_ep_acked     = r_acked;
    assign tx_pkt_start    = w_tx_start;
    assign tx_pid          = w_tx_pid;
    assign tx_data_avail   = w_avail;
    assign tx_data         = r_tx_data;
endmodule
